// File: rtl/uart_pkg.sv
// Shared FSM encoding and 8N1 frame geometry for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS  = 8;
    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read and a sticky drop flag.
// A write is dropped whenever the pre-edge count is full, even if a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_full;
    logic             w_empty;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_full   = (r_count == (AW + 1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_do_wr  = wr_en && !w_full;
    assign w_do_rd  = rd_en && !w_empty;

    assign dout     = r_mem[r_rd_ptr];
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

    // Storage is not reset: clearing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (w_do_wr)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (wr_en && w_full)
                r_overflow <= 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/out_uart_tx.sv
// 8N1 serial transmitter for the output register; the first start bit follows a write by one cycle.
// Writes are buffered in a FIFO; when it is full a byte is dropped and the sticky overflow is set.
module out_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       empty,
    output logic       full,
    output logic       overflow
);
    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;

    logic          w_empty;
    logic          w_baud_end;
    logic          w_pop;
    logic [7:0]    w_head;

    assign w_baud_end = (r_baud == BAUD_LAST);
    // Pop from IDLE, or at the very last stop-bit cycle so frames run back to back.
    assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (w_pop),
        .din      (data_in),
        .dout     (w_head),
        .full     (full),
        .empty    (w_empty),
        .overflow (overflow)
    );

    assign tx    = r_tx;
    assign busy  = r_busy;
    assign empty = w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// Self-checking bench: a line-level receiver decodes frames from tx and the tasks compare against expected bytes.
module tb_out_uart_tx;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic       empty;
    logic       full;
    logic       overflow;

    int checks;
    int errors;
    int cyc;

    out_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .tx       (tx),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Serial receiver: samples every cycle, checks each of the 10 bit slots is a
    // constant CPB-cycle level with a low start and high stop, and decodes LSB first.
    logic       samp [FRAME];
    logic       mon_active;
    int         mon_n;
    int         mon_start;
    logic [7:0] mon_byte;
    bit         mon_ok;
    logic [7:0] rx_byte_q [$];
    bit         rx_ok_q   [$];
    int         rx_start_q[$];

    initial mon_active = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_start  = cyc;
                    samp[0]    = 1'b0;
                    mon_n      = 1;
                end
            end else begin
                samp[mon_n] = tx;
                mon_n++;
            end
            if (mon_active && mon_n == FRAME) begin
                mon_ok = 1'b1;
                for (int s = 0; s < 10; s++) begin
                    for (int k = 1; k < CPB; k++)
                        if (samp[s*CPB+k] !== samp[s*CPB]) mon_ok = 1'b0;
                    if (s >= 1 && s <= 8) mon_byte[s-1] = samp[s*CPB];
                end
                if (samp[0] !== 1'b0) mon_ok = 1'b0;
                if (samp[9*CPB] !== 1'b1) mon_ok = 1'b0;
                rx_byte_q.push_back(mon_byte);
                rx_ok_q.push_back(mon_ok);
                rx_start_q.push_back(mon_start);
                mon_active = 1'b0;
            end
        end
    end

    task automatic clear_rx;
        rx_byte_q.delete();
        rx_ok_q.delete();
        rx_start_q.delete();
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_rx();
    endtask

    task automatic wait_drain(output bit timeout, output bit saw_full);
        int n;
        n = 0;
        saw_full = 1'b0;
        do begin
            @(negedge clk);
            if (full) saw_full = 1'b1;
            n++;
        end while (!(busy == 1'b0 && empty == 1'b1 && !mon_active) && n < 3000);
        timeout = (n >= 3000);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] b;
        checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        // Six back-to-back writes guarantee a dropped byte, then reset lands mid-frame.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b = 8'($urandom);
            wr_en = 1'b1; data_in = b;
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pre_reset_overflow: got %b want 1", overflow); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL async_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL async_empty: got %b want 1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL async_overflow: got %b want 0", overflow); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rx_byte_q.size() != 0) begin errors++; $display("FAIL abandoned_frame: got %0d frames want 0", rx_byte_q.size()); end
        clear_rx();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single;
        int n;
        bit to, sf;
        @(negedge clk);
        wr_en = 1'b1; data_in = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b0)
            begin errors++; $display("FAIL single_after_write: got tx=%b busy=%b empty=%b want 1 0 0", tx, busy, empty); end
        @(negedge clk);
        checks++; if (tx !== 1'b0 || busy !== 1'b1 || empty !== 1'b1)
            begin errors++; $display("FAIL single_start: got tx=%b busy=%b empty=%b want 0 1 1", tx, busy, empty); end
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != FRAME) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", n, FRAME); end
        wait_drain(to, sf);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: got timeout want drain"); end
        checks++; if (rx_byte_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", rx_byte_q.size()); end
        else begin
            checks++; if (rx_byte_q[0] !== 8'hA5) begin errors++; $display("FAIL single_byte: got %h want a5", rx_byte_q[0]); end
            checks++; if (!rx_ok_q[0]) begin errors++; $display("FAIL single_frame_shape: got malformed want 8N1"); end
        end
        clear_rx();
    endtask

    task automatic test_back_to_back;
        bit to, sf;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en = 1'b1; data_in = exp_b[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_drain(to, sf);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got timeout want drain"); end
        checks++; if (rx_byte_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", rx_byte_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (rx_byte_q[i] !== exp_b[i] || !rx_ok_q[i])
                    begin errors++; $display("FAIL b2b_byte%0d: got %h ok=%0d want %h ok=1", i, rx_byte_q[i], rx_ok_q[i], exp_b[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++; if (rx_start_q[i] - rx_start_q[i-1] != FRAME)
                    begin errors++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, rx_start_q[i] - rx_start_q[i-1], FRAME); end
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", empty); end
        clear_rx();
    endtask

    task automatic test_wrap;
        bit to, sf, any_full;
        logic [7:0] exp_q [$];
        logic [7:0] b;
        any_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b = 8'($urandom);
            exp_q.push_back(b);
            wr_en = 1'b1; data_in = b;
            @(negedge clk);
            wr_en = 1'b0;
            wait_drain(to, sf);
            if (sf) any_full = 1'b1;
            checks++; if (to) begin errors++; $display("FAIL wrap_timeout%0d: got timeout want drain", i); end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        checks++; if (any_full) begin errors++; $display("FAIL wrap_full: got full=1 seen want never"); end
        checks++; if (rx_byte_q.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d want 10", rx_byte_q.size()); end
        else begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (rx_byte_q[i] !== exp_q[i] || !rx_ok_q[i])
                    begin errors++; $display("FAIL wrap_byte%0d: got %h ok=%0d want %h", i, rx_byte_q[i], rx_ok_q[i], exp_q[i]); end
            end
        end
        clear_rx();
    endtask

    task automatic test_random_burst;
        bit to, sf;
        int len;
        logic [7:0] exp_q [$];
        logic [7:0] b;
        for (int r = 0; r < 4; r++) begin
            exp_q.delete();
            len = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                b = 8'($urandom);
                exp_q.push_back(b);
                wr_en = 1'b1; data_in = b;
            end
            @(negedge clk);
            wr_en = 1'b0;
            wait_drain(to, sf);
            checks++; if (to) begin errors++; $display("FAIL burst%0d_timeout: got timeout want drain", r); end
            checks++; if (rx_byte_q.size() != len)
                begin errors++; $display("FAIL burst%0d_count: got %0d want %0d", r, rx_byte_q.size(), len); end
            else begin
                for (int i = 0; i < len; i++) begin
                    checks++; if (rx_byte_q[i] !== exp_q[i] || !rx_ok_q[i])
                        begin errors++; $display("FAIL burst%0d_byte%0d: got %h want %h", r, i, rx_byte_q[i], exp_q[i]); end
                end
            end
            clear_rx();
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow;
        bit to, sf;
        logic [7:0] b [6];
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                checks++; if (full !== 1'b1 || overflow !== 1'b0)
                    begin errors++; $display("FAIL ovf_before: got full=%b ovf=%b want 1 0", full, overflow); end
            end
            wr_en = 1'b1; data_in = b[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        wait_drain(to, sf);
        checks++; if (to) begin errors++; $display("FAIL ovf_timeout: got timeout want drain"); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        checks++; if (rx_byte_q.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d want 5", rx_byte_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (rx_byte_q[i] !== b[i] || !rx_ok_q[i])
                    begin errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_byte_q[i], b[i]); end
            end
        end
        clear_rx();
    endtask

    task automatic test_simul_full;
        bit to, sf;
        logic [7:0] b [6];
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en = 1'b1; data_in = b[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
        // First frame started one edge after the first write; its last stop cycle ends 80 edges later.
        repeat (FRAME - 4) @(negedge clk);
        checks++; if (full !== 1'b1 || overflow !== 1'b0 || tx !== 1'b1)
            begin errors++; $display("FAIL simul_pre: got full=%b ovf=%b tx=%b want 1 0 1", full, overflow, tx); end
        wr_en = 1'b1; data_in = b[5];
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL simul_ovf: got %b want 1", overflow); end
        checks++; if (full !== 1'b0 || empty !== 1'b0)
            begin errors++; $display("FAIL simul_count: got full=%b empty=%b want 0 0", full, empty); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL simul_restart: got tx=%b want 0", tx); end
        wait_drain(to, sf);
        checks++; if (to) begin errors++; $display("FAIL simul_timeout: got timeout want drain"); end
        checks++; if (rx_byte_q.size() != 5) begin errors++; $display("FAIL simul_frames: got %0d want 5", rx_byte_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (rx_byte_q[i] !== b[i] || !rx_ok_q[i])
                    begin errors++; $display("FAIL simul_byte%0d: got %h want %h", i, rx_byte_q[i], b[i]); end
            end
        end
        clear_rx();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_random_burst();
        test_overflow();
        do_reset();
        test_simul_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
